// File: rtl/pcm_frame_packer.sv
// Serialises one multi-channel PCM frame per sample strobe into a byte-wide FIFO write port.
// Optional sync header, per-frame byte order, and a saturating count of dropped frames.
module pcm_frame_packer #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned HEADER_EN    = 0,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
  parameter int unsigned OVF_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] sample_i,
  input  logic                           sample_valid_i,
  input  logic                           big_endian_i,
  input  logic                           fifo_full_i,
  output logic                           fifo_wr_en_o,
  output logic [7:0]                     fifo_write_data_o,
  output logic                           busy_o,
  output logic [OVF_WIDTH-1:0]           overflow_count_o
);

  localparam int unsigned Bps    = SAMPLE_WIDTH / 8;
  localparam int unsigned Total  = HEADER_EN + NUM_CH * Bps;
  localparam int unsigned IdxW   = $clog2(Total + 1);
  localparam int unsigned FrameW = NUM_CH * SAMPLE_WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Total - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                state_q, state_d;
  logic [FrameW-1:0]     frame_q, frame_d;
  logic                  order_q, order_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [OVF_WIDTH-1:0]  ovf_q, ovf_d;
  logic                  wr_en, last_byte, capture, drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      frame_q <= '0;
      order_q <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      order_q <= order_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    last_byte = wr_en && (idx_q == LastIdx);
    // A strobe on the final write cycle chains straight into the next frame.
    capture   = sample_valid_i && ((state_q == StIdle) || last_byte);
    drop      = sample_valid_i && (state_q == StSend) && !last_byte;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sample_valid_i) state_d = StSend;
      StSend:  if (last_byte && !sample_valid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    frame_d = frame_q;
    order_d = order_q;
    idx_d   = idx_q;
    if (capture) begin
      frame_d = sample_i;
      order_d = big_endian_i;
      idx_d   = '0;
    end else if (wr_en) begin
      idx_d = idx_q + IdxW'(1);
    end

    ovf_d = ovf_q;
    if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_WIDTH'(1);
  end

  always_comb begin
    wr_en             = (state_q == StSend) && !fifo_full_i;
    busy_o            = (state_q == StSend);
    fifo_wr_en_o      = wr_en;
    overflow_count_o  = ovf_q;
    fifo_write_data_o = 8'h00;
    if (state_q == StSend) begin
      if ((HEADER_EN != 0) && (idx_q == '0)) fifo_write_data_o = HEADER_BYTE;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned b = 0; b < Bps; b++) begin
          if (idx_q == IdxW'(HEADER_EN + c * Bps + b)) begin
            fifo_write_data_o =
              frame_q[c * SAMPLE_WIDTH + (order_q ? (Bps - 1 - b) : b) * 8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Bench for pcm_frame_packer: two instances (defaults, and 2x24-bit with header and 2-bit
// overflow counter) checked every cycle against a byte-list model, plus directed literal cases.
module tb_pcm_frame_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] smp = '0;
  logic        valid = 1'b0;
  logic        be = 1'b0;
  logic        full = 1'b0;
  logic        mon_en = 1'b0;

  logic        wr0, busy0, wr1, busy1;
  logic [7:0]  data0, data1;
  logic [15:0] ovf0;
  logic [1:0]  ovf1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcm_frame_packer dut0 (
    .clk               (clk),
    .rst_n             (rst_n),
    .sample_i          (smp[15:0]),
    .sample_valid_i    (valid),
    .big_endian_i      (be),
    .fifo_full_i       (full),
    .fifo_wr_en_o      (wr0),
    .fifo_write_data_o (data0),
    .busy_o            (busy0),
    .overflow_count_o  (ovf0)
  );

  pcm_frame_packer #(
    .SAMPLE_WIDTH (24),
    .NUM_CH       (2),
    .HEADER_EN    (1),
    .HEADER_BYTE  (8'hA5),
    .OVF_WIDTH    (2)
  ) dut1 (
    .clk               (clk),
    .rst_n             (rst_n),
    .sample_i          (smp),
    .sample_valid_i    (valid),
    .big_endian_i      (be),
    .fifo_full_i       (full),
    .fifo_wr_en_o      (wr1),
    .fifo_write_data_o (data1),
    .busy_o            (busy1),
    .overflow_count_o  (ovf1)
  );

  // Model: each instance holds the byte list of the frame in flight and a read position.
  int         p_sw[2]     = '{16, 24};
  int         p_nch[2]    = '{1, 2};
  int         p_hdr[2]    = '{0, 1};
  int         p_ovfmax[2] = '{65535, 3};
  logic [7:0] mb[2][16];
  int         mlen[2]     = '{0, 0};
  int         mpos[2]     = '{0, 0};
  int         movf[2]     = '{0, 0};

  task automatic load(input int i);
    int k;
    int bps;
    int pos;
    k = 0;
    bps = p_sw[i] / 8;
    if (p_hdr[i] != 0) begin
      mb[i][0] = 8'hA5;
      k = 1;
    end
    for (int c = 0; c < p_nch[i]; c++) begin
      for (int b = 0; b < bps; b++) begin
        pos = be ? (bps - 1 - b) : b;
        mb[i][k] = 8'(smp >> (c * p_sw[i] + pos * 8));
        k = k + 1;
      end
    end
    mlen[i] = k;
    mpos[i] = 0;
  endtask

  always @(negedge clk) begin
    logic        e_busy, e_wr, a_busy, a_wr;
    logic [7:0]  e_data, a_data;
    logic [15:0] a_ovf;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        e_busy = (mpos[i] < mlen[i]);
        e_wr   = e_busy && !full;
        e_data = e_busy ? mb[i][mpos[i]] : 8'h00;
        a_busy = (i == 0) ? busy0 : busy1;
        a_wr   = (i == 0) ? wr0 : wr1;
        a_data = (i == 0) ? data0 : data1;
        a_ovf  = (i == 0) ? ovf0 : {14'b0, ovf1};
        checks++;
        if (a_busy !== e_busy || a_wr !== e_wr || a_data !== e_data || a_ovf !== 16'(movf[i]))
        begin
          failures++;
          $display("FAIL model_cmp dut%0d t=%0t: got busy=%b wr=%b data=%h ovf=%0d, want busy=%b wr=%b data=%h ovf=%0d",
                   i, $time, a_busy, a_wr, a_data, a_ovf, e_busy, e_wr, e_data, movf[i]);
        end
        // Advance to the state after the coming rising edge.
        if (!rst_n) begin
          mlen[i] = 0;
          mpos[i] = 0;
          movf[i] = 0;
        end else begin
          if (e_wr) mpos[i] = mpos[i] + 1;
          if (valid && (!e_busy || (e_wr && mpos[i] == mlen[i]))) load(i);
          else if (valid && movf[i] < p_ovfmax[i]) movf[i] = movf[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    full  = 1'b0;
    be    = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
  endtask

  logic [7:0] exp3[7] = '{8'hA5, 8'hCC, 8'hBB, 8'hAA, 8'h33, 8'h22, 8'h11};
  logic [7:0] exp5[6] = '{8'h21, 8'h11, 8'h23, 8'h13, 8'h25, 8'h15};

  initial begin
    cyc();
    mon_en = 1'b1;

    // Little-endian 16-bit frame.
    do_reset();
    #1 chk("rst_busy", busy0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_data", data0, 8'h00);
    valid = 1'b1; smp = 48'hA55A; be = 1'b0;
    cyc(); valid = 1'b0;
    #1 chk("le_b0_wr", wr0, 1);
    chk("le_b0_data", data0, 8'h5A);
    cyc();
    #1 chk("le_b1_data", data0, 8'hA5);
    chk("le_b1_busy", busy0, 1);
    cyc();
    #1 chk("le_done_busy", busy0, 0);
    chk("le_done_wr", wr0, 0);
    chk("le_ovf", ovf0, 0);

    // Big-endian frame; order input toggles mid-frame without effect.
    do_reset();
    valid = 1'b1; smp = 48'hA55A; be = 1'b1;
    cyc(); valid = 1'b0; be = 1'b0;
    #1 chk("be_b0_data", data0, 8'hA5);
    cyc();
    #1 chk("be_b1_data", data0, 8'h5A);

    // Header plus two 24-bit channels.
    do_reset();
    valid = 1'b1; smp = {24'h112233, 24'hAABBCC}; be = 1'b0;
    cyc(); valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      #1 chk("hdr_wr", wr1, 1);
      chk("hdr_data", data1, exp3[k]);
      cyc();
    end
    #1 chk("hdr_done_busy", busy1, 0);

    // Stall five cycles on the second byte.
    do_reset();
    valid = 1'b1; smp = 48'hA55A;
    cyc(); valid = 1'b0;
    #1 chk("stall_b0_data", data0, 8'h5A);
    for (int k = 0; k < 5; k++) begin
      cyc(); full = 1'b1;
      #1 chk("stall_wr_low", wr0, 0);
      chk("stall_hold_data", data0, 8'hA5);
    end
    cyc(); full = 1'b0;
    #1 chk("stall_resume_wr", wr0, 1);
    chk("stall_resume_data", data0, 8'hA5);
    cyc();
    #1 chk("stall_done_busy", busy0, 0);

    // Strobe every cycle for six cycles.
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      valid = 1'b1;
      smp = {32'h0, 8'(8'h10 + k), 8'(8'h20 + k)};
      #1 if (k > 1) chk("b2b_data", data0, exp5[k - 2]);
      cyc();
    end
    valid = 1'b0;
    #1 chk("b2b_last_data", data0, exp5[5]);
    chk("b2b_last_wr", wr0, 1);
    cyc();
    #1 chk("b2b_idle", busy0, 0);
    chk("b2b_ovf", ovf0, 3);
    chk("ovf_saturate", ovf1, 3);

    // Reset right after the first byte.
    do_reset();
    valid = 1'b1; smp = 48'hA55A;
    cyc(); valid = 1'b0; rst_n = 1'b0;
    #1 chk("rstmid_b0_data", data0, 8'h5A);
    cyc(); rst_n = 1'b1;
    #1 chk("rstmid_busy", busy0, 0);
    chk("rstmid_wr", wr0, 0);
    chk("rstmid_ovf", ovf0, 0);
    valid = 1'b1;
    cyc(); valid = 1'b0;
    #1 chk("rstmid_new_b0", data0, 8'h5A);
    cyc();
    #1 chk("rstmid_new_b1", data0, 8'hA5);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      valid = ($urandom % 4) == 0;
      full  = ($urandom % 3) == 0;
      be    = $urandom % 2;
      smp   = {16'($urandom), 32'($urandom)};
      rst_n = ($urandom % 250) != 0;
      cyc();
    end
    rst_n = 1'b1; valid = 1'b0; full = 1'b0;
    repeat (12) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
